tick_rate_ctrl: RTL and testbench



---
 rtl/tick_rate_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_tick_rate_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_rate_ctrl.sv
// tick_rate_ctrl
//   Programmable tick scheduler. It produces a single-cycle enable strobe
//   (tick) and a toggling slow clock (clk_out) from clk. It runs in one of two
//   modes: free-running, or a counted burst of step_cnt ticks. The divisor can
//   be changed at runtime through a div_wr / div_ack handshake. A new divisor
//   only takes effect on a period boundary, so no period is ever truncated.
//
//   Optional feature: define TICK_MIDPHASE_EN to add the tick_mid output. It
//   is a strobe at mid-period, for use as a 90-degree-offset sampling enable.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   run       in   level, request free-running ticks
//   step_go   in   pulse, start a burst of step_cnt ticks
//   step_cnt  in   burst length, sampled when step_go is accepted
//   div_wr    in   pulse, request a divisor change
//   div_val   in   new divisor, sampled with div_wr
//   div_ack   out  one-cycle pulse, first cycle the new divisor is active
//   tick      out  registered one-cycle enable strobe
//   clk_out   out  toggles on every tick
//   tick_mid  out  mid-period strobe (only with TICK_MIDPHASE_EN)
//   busy      out  high while a burst is in progress
//   done      out  one-cycle pulse at burst completion
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | count held at 0, no ticks, clk_out holds
// RUN   | free-running, count wraps every eff cycles
// BURST | counting as RUN, remaining ticks tracked, returns to IDLE at end

module tick_rate_ctrl #(
    parameter int unsigned DEFAULT_DIV = 250_000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned BURST_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step_go,
    input  logic [BURST_W-1:0] step_cnt,
    input  logic               div_wr,
    input  logic [CNT_W-1:0]   div_val,
    output logic               div_ack,
    output logic               tick,
    output logic               clk_out,
    output logic               busy,
`ifdef TICK_MIDPHASE_EN
    output logic               tick_mid,
`endif
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   cur_div;
    logic [CNT_W-1:0]   pend_val;
    logic               pend_vld;
    logic [BURST_W-1:0] remaining;

    logic [CNT_W-1:0]   eff;
    logic               wrap;
    logic               apply_edge;
    logic               do_apply;
    logic [CNT_W-1:0]   new_div;

    // Divisors 0 and 1 both mean "a tick every cycle".
    assign eff  = (cur_div == '0) ? CNT_W'(1) : cur_div;
    assign wrap = (state != IDLE) && (count == eff - CNT_W'(1));

    // In IDLE there is no period to protect, so a pending divisor goes in on
    // the next edge. While counting, it waits for the wrap. A div_wr that
    // lands on the apply edge bypasses the pending register and wins.
    assign apply_edge = (state == IDLE) ? pend_vld : wrap;
    assign do_apply   = apply_edge && (pend_vld || div_wr);
    assign new_div    = div_wr ? div_val : pend_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            remaining <= '0;
            tick      <= 1'b0;
            clk_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (run) begin
                        state <= RUN;
                    end else if (step_go) begin
                        if (step_cnt != '0) begin
                            state     <= BURST;
                            remaining <= step_cnt;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (wrap) begin
                        count   <= '0;
                        tick    <= 1'b1;
                        clk_out <= ~clk_out;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                    // A wrap on the leaving edge still delivers its tick above.
                    if (!run) begin
                        state <= IDLE;
                        count <= '0;
                    end
                end

                BURST: begin
                    if (wrap) begin
                        count     <= '0;
                        tick      <= 1'b1;
                        clk_out   <= ~clk_out;
                        remaining <= remaining - BURST_W'(1);
                        if (remaining == BURST_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_div  <= CNT_W'(DEFAULT_DIV);
            pend_val <= '0;
            pend_vld <= 1'b0;
            div_ack  <= 1'b0;
        end else begin
            div_ack <= 1'b0;
            if (do_apply) begin
                cur_div  <= new_div;
                pend_vld <= 1'b0;
                div_ack  <= 1'b1;
            end else if (div_wr) begin
                pend_val <= div_val;
                pend_vld <= 1'b1;
            end
        end
    end

`ifdef TICK_MIDPHASE_EN
    logic [CNT_W-1:0] mid_cnt;

    // For eff below 2 there is no distinct mid point, so tick_mid stays low.
    assign mid_cnt = (eff >> 1) - CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_mid <= 1'b0;
        end else begin
            tick_mid <= (state != IDLE) && (eff > CNT_W'(1)) && (count == mid_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_tick_rate_ctrl.sv
module tb_tick_rate_ctrl;

    localparam int CNT_W   = 32;
    localparam int BURST_W = 8;

    logic               clk      = 1'b0;
    logic               rst      = 1'b1;
    logic               run      = 1'b0;
    logic               step_go  = 1'b0;
    logic [BURST_W-1:0] step_cnt = '0;
    logic               div_wr   = 1'b0;
    logic [CNT_W-1:0]   div_val  = '0;
    logic               div_ack;
    logic               tick;
    logic               clk_out;
    logic               busy;
    logic               done;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] c;
        logic        tk;
        logic        dn;
        logic        ak;
        logic        co;
        logic        by;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_act;
    ev_t mon_exp;

    tick_rate_ctrl #(
        .DEFAULT_DIV (4),
        .CNT_W       (CNT_W),
        .BURST_W     (BURST_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .step_go  (step_go),
        .step_cnt (step_cnt),
        .div_wr   (div_wr),
        .div_val  (div_val),
        .div_ack  (div_ack),
        .tick     (tick),
        .clk_out  (clk_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle that shows tick, done or div_ack consumes one
    // expected event and compares cycle number plus all flags.
    always @(negedge clk) begin
        if (rst === 1'b0 && (tick || done || div_ack)) begin
            mon_act = {32'(cyc), tick, done, div_ack, clk_out, busy};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL event_unexpected: got cyc=%0d tick=%b done=%b ack=%b clk_out=%b busy=%b, required no event",
                         cyc, tick, done, div_ack, clk_out, busy);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_bad++;
                    $display("FAIL event: got cyc=%0d tick=%b done=%b ack=%b clk_out=%b busy=%b, required cyc=%0d tick=%b done=%b ack=%b clk_out=%b busy=%b",
                             mon_act.c, mon_act.tk, mon_act.dn, mon_act.ak, mon_act.co, mon_act.by,
                             mon_exp.c, mon_exp.tk, mon_exp.dn, mon_exp.ak, mon_exp.co, mon_exp.by);
                end
            end
        end
    end

    task automatic push(input int c, input logic tk, input logic dn,
                        input logic ak, input logic co, input logic by);
        exp_q.push_back({32'(c), tk, dn, ak, co, by});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto(input int c);
        if (cyc > c) begin
            n_cmp++;
            n_bad++;
            $display("FAIL schedule: got cycle %0d, required at most %0d", cyc, c);
        end
        while (cyc < c) step(1);
    endtask

    task automatic pulse_div(input int c, input logic [CNT_W-1:0] v);
        goto(c);
        div_wr  = 1'b1;
        div_val = v;
        step(1);
        div_wr  = 1'b0;
    endtask

    task automatic pulse_step(input int c, input logic [BURST_W-1:0] n);
        goto(c);
        step_go  = 1'b1;
        step_cnt = n;
        step(1);
        step_go  = 1'b0;
    endtask

    int c0, b0, b1, d0, s, z, e0, p, q0, q, r;

    initial begin
        // Reset state
        step(3);
        chk("rst_tick",    32'(tick),    0);
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_busy",    32'(busy),    0);
        chk("rst_done",    32'(done),    0);
        chk("rst_div_ack", 32'(div_ack), 0);
        rst = 1'b0;
        step(1);

        // Free run at div 4, change to 2 mid-period, then a coincident
        // double write (7 then 3 on the wrap edge), then stop on a wrap edge.
        c0 = cyc;
        push(c0 + 5,  1, 0, 0, 1, 0);
        push(c0 + 9,  1, 0, 0, 0, 0);
        push(c0 + 13, 1, 0, 0, 1, 0);
        push(c0 + 17, 1, 0, 1, 0, 0);
        push(c0 + 19, 1, 0, 0, 1, 0);
        push(c0 + 21, 1, 0, 0, 0, 0);
        push(c0 + 23, 1, 0, 1, 1, 0);
        push(c0 + 26, 1, 0, 0, 0, 0);
        push(c0 + 29, 1, 0, 0, 1, 0);
        run = 1'b1;
        pulse_div(c0 + 14, 2);
        pulse_div(c0 + 21, 7);
        pulse_div(c0 + 22, 3);
        goto(c0 + 28);
        run = 1'b0;

        // Back to div 4 in IDLE, burst of 3 with an ignored step_go.
        b0 = c0 + 33;
        b1 = b0 + 4;
        push(b0 + 2,  0, 0, 1, 1, 0);
        push(b1 + 5,  1, 0, 0, 0, 1);
        push(b1 + 9,  1, 0, 0, 1, 1);
        push(b1 + 13, 1, 1, 0, 0, 0);
        pulse_div(b0, 4);
        pulse_step(b1, 3);
        chk("busy_burst_start", 32'(busy), 1);
        pulse_step(b1 + 6, 7);
        goto(b1 + 14);
        chk("busy_after_burst", 32'(busy), 0);

        // Divisor 0: five back-to-back ticks; then a zero-length burst.
        d0 = b1 + 17;
        s  = d0 + 4;
        z  = s + 9;
        push(d0 + 2, 0, 0, 1, 0, 0);
        push(s + 2,  1, 0, 0, 1, 1);
        push(s + 3,  1, 0, 0, 0, 1);
        push(s + 4,  1, 0, 0, 1, 1);
        push(s + 5,  1, 0, 0, 0, 1);
        push(s + 6,  1, 1, 0, 1, 0);
        push(z + 1,  0, 1, 0, 1, 0);
        pulse_div(d0, 0);
        pulse_step(s, 5);
        pulse_step(z, 0);
        goto(z + 2);
        chk("busy_zero_step", 32'(busy), 0);

        // Burst at div 6 with two writes (7, 3) in one period: one ack,
        // new period 3 starting at the next wrap.
        e0 = z + 4;
        p  = e0 + 4;
        push(e0 + 2, 0, 0, 1, 1, 0);
        push(p + 7,  1, 0, 0, 0, 1);
        push(p + 13, 1, 0, 1, 1, 1);
        push(p + 16, 1, 1, 0, 0, 0);
        pulse_div(e0, 6);
        pulse_step(p, 3);
        pulse_div(p + 8, 7);
        pulse_div(p + 10, 3);

        // Reset mid-burst with a divisor of 9 still pending.
        q0 = p + 19;
        q  = q0 + 4;
        push(q0 + 2, 0, 0, 1, 0, 0);
        push(q + 7,  1, 0, 0, 1, 1);
        pulse_div(q0, 6);
        pulse_step(q, 4);
        pulse_div(q + 9, 9);
        goto(q + 11);
        chk("pre_rst_busy",    32'(busy),    1);
        chk("pre_rst_clk_out", 32'(clk_out), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tick",    32'(tick),    0);
        chk("mid_rst_busy",    32'(busy),    0);
        chk("mid_rst_clk_out", 32'(clk_out), 0);
        chk("mid_rst_done",    32'(done),    0);
        chk("mid_rst_div_ack", 32'(div_ack), 0);
        goto(q + 13);
        rst = 1'b0;

        // After reset: divisor back to 4, no ack from the discarded value.
        r = q + 14;
        push(r + 5, 1, 0, 0, 1, 0);
        push(r + 9, 1, 0, 0, 0, 0);
        goto(r);
        run = 1'b1;
        goto(r + 10);
        run = 1'b0;
        goto(r + 20);
        chk("events_outstanding", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
